// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
// FIFO geometry and AXI burst length encoding (beats = len + 1).
package fifo_rd_stream_adapter_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int FIFO_RD_LAT   = 2;
    localparam int AXI_LEN_WIDTH = 8;
    localparam int AXI_MAX_BEATS = 1 << AXI_LEN_WIDTH;
    localparam int OUT_BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus outgoing valid/ready stream of the adapter.
// master = adapter side, slave = FIFO/sink environment side.
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8
);
    logic                 fifo_rd_en_o;
    logic [WIDTH-1:0]     fifo_rdata_i;
    logic                 fifo_empty_i;
    logic [LEN_WIDTH-1:0] burst_len_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [WIDTH-1:0]     m_data_o;
    logic                 m_last_o;
    logic                 busy_o;

    modport master (
        output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o,
        input  fifo_rdata_i, fifo_empty_i, burst_len_i, m_ready_i
    );

    modport slave (
        input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o,
        output fifo_rdata_i, fifo_empty_i, burst_len_i, m_ready_i
    );
endinterface

// File: rtl/fifo_rd_stream_adapter_stream_out_buf.sv
// Circular output buffer holding words returned by the FIFO.
// Head entry is presented directly as stream data.
module stream_out_buf
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = OUT_BUF_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_data = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= nxt(tail);
            end
            if (rd_en) head <= nxt(head);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Pops a 2-cycle-latency FIFO and frames the words as a burst stream.
// Pop control and beat/last framing live here; storage is stream_out_buf.
module fifo_rd_stream_adapter
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter int WIDTH     = DATA_WIDTH,
    parameter int BUF_DEPTH = OUT_BUF_DEPTH,
    parameter int LEN_WIDTH = AXI_LEN_WIDTH
) (
    input logic                      clk_i,
    input logic                      rst_i,
    fifo_rd_stream_adapter_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = CW + 1;

    logic                 pop_d1;
    logic                 pop_d2;
    logic [CW-1:0]        buf_count;
    logic [SW-1:0]        resv;
    logic                 valid;
    logic                 hs;
    logic                 last;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] eff_len;

    // The empty flag is stale right after a pop, so never pop twice in a row.
    assign resv = SW'(buf_count) + SW'(pop_d2);
    assign bus.fifo_rd_en_o = !rst_i && !bus.fifo_empty_i && !pop_d1
                              && (resv < SW'(BUF_DEPTH));

    assign valid   = (buf_count != '0);
    assign hs      = valid && bus.m_ready_i;
    assign eff_len = (beat_cnt == '0) ? bus.burst_len_i : len_q;
    assign last    = valid && (beat_cnt == eff_len);

    assign bus.m_valid_o = valid;
    assign bus.m_last_o  = last;
    assign bus.busy_o    = pop_d1 | pop_d2 | valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pop_d1   <= 1'b0;
            pop_d2   <= 1'b0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            pop_d1 <= bus.fifo_rd_en_o;
            pop_d2 <= pop_d1;
            if (hs) begin
                if (beat_cnt == '0) len_q <= bus.burst_len_i;
                beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    stream_out_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (pop_d2),
        .wr_data (bus.fifo_rdata_i),
        .rd_en   (hs),
        .rd_data (bus.m_data_o),
        .count   (buf_count)
    );
endmodule
